// File: rtl/hazard_controller.sv
// Decode-stage hazard controller: tracks in-flight destination registers and
// decides each cycle whether the front end runs, stalls (bubble) or flushes.
module hazard_controller #(
  parameter int FORWARDING   = 1,
  parameter int WINDOW       = 3,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] if_instr,
  input  logic        if_valid,
  input  logic        ex_redirect,
  input  logic        mem_busy,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        decode_flush,
  output logic        stall,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam logic [2:0] FC_INIT = 3'(FLUSH_CYCLES);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    return (op == OP_REG) || (op == OP_STORE) || (op == OP_BRANCH) ||
           (op == OP_IMM) || (op == OP_LOAD)  || (op == OP_JALR);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_REG) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  function automatic logic writes_rd(input logic [6:0] op);
    return (op == OP_REG)  || (op == OP_IMM)   || (op == OP_LOAD) ||
           (op == OP_JALR) || (op == OP_LUI)   || (op == OP_AUIPC) ||
           (op == OP_JAL);
  endfunction

  logic [6:0] opcode;
  logic [4:0] rs1, rs2, rd;
  logic       use1, use2;
  logic       dec_vld, dec_ld;
  logic       unused_instr_bits;

  assign opcode  = if_instr[6:0];
  assign rd      = if_instr[11:7];
  assign rs1     = if_instr[19:15];
  assign rs2     = if_instr[24:20];
  assign use1    = uses_rs1(opcode) && (rs1 != 5'd0);
  assign use2    = uses_rs2(opcode) && (rs2 != 5'd0);
  assign dec_vld = if_valid && writes_rd(opcode) && (rd != 5'd0);
  assign dec_ld  = (opcode == OP_LOAD);
  assign unused_instr_bits = ^{if_instr[31:25], if_instr[14:12]};

  logic [0:0]        state;
  logic [2:0]        fc;
  logic [WINDOW-1:0] win_vld;
  logic [4:0]        win_rd [WINDOW];
  logic              win_ld [WINDOW];

  logic raw_hit, hazard;
  logic adv, load_instr;

  // With forwarding only a load sitting in ID/EX can't be bypassed in time.
  always_comb begin
    raw_hit = 1'b0;
    for (int k = 0; k < WINDOW; k++) begin
      if (win_vld[k] && ((FORWARDING == 0) || ((k == 0) && win_ld[k]))) begin
        if (use1 && (rs1 == win_rd[k])) raw_hit = 1'b1;
        if (use2 && (rs2 == win_rd[k])) raw_hit = 1'b1;
      end
    end
    hazard = if_valid && raw_hit;
  end

  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    decode_flush = 1'b0;
    stall        = 1'b0;
    adv          = 1'b0;
    load_instr   = 1'b0;
    if (reset) begin
      decode_flush = 1'b1;
    end else if (!mem_busy) begin
      adv = 1'b1;
      if (ex_redirect || (state == ST_FLUSH)) begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        decode_flush = 1'b1;
      end else if (hazard) begin
        decode_flush = 1'b1;
        stall        = 1'b1;
      end else begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        load_instr = 1'b1;
      end
    end
  end

  // Control state: FSM, window valid bits and counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      fc          <= 3'd0;
      win_vld     <= '0;
      stall_count <= 16'd0;
      flush_count <= 16'd0;
    end else if (adv) begin
      win_vld[0] <= load_instr && dec_vld;
      for (int k = 1; k < WINDOW; k++) begin
        win_vld[k] <= win_vld[k-1];
      end
      if (ex_redirect) begin
        flush_count <= sat_inc(flush_count);
        if (FC_INIT != 3'd0) begin
          state <= ST_FLUSH;
          fc    <= FC_INIT;
        end else begin
          state <= ST_RUN;
          fc    <= 3'd0;
        end
      end else if (state == ST_FLUSH) begin
        if (fc <= 3'd1) begin
          state <= ST_RUN;
          fc    <= 3'd0;
        end else begin
          fc <= fc - 3'd1;
        end
      end else if (stall) begin
        stall_count <= sat_inc(stall_count);
      end
    end
  end

  // Window payload; meaningless whenever the matching valid bit is clear.
  always_ff @(posedge clock) begin
    if (adv) begin
      win_rd[0] <= rd;
      win_ld[0] <= dec_ld;
      for (int k = 1; k < WINDOW; k++) begin
        win_rd[k] <= win_rd[k-1];
        win_ld[k] <= win_ld[k-1];
      end
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: two configurations share one stimulus stream,
// checked against a directed vector table and a tick-based reference model.
module tb_hazard_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] if_instr;
  logic        if_valid, ex_redirect, mem_busy;

  logic        a_pc, a_ifid, a_fl, a_st;
  logic [15:0] a_sc, a_fc;
  logic        b_pc, b_ifid, b_fl, b_st;
  logic [15:0] b_sc, b_fc;

  always #5 clock = ~clock;

  hazard_controller #(.FORWARDING(1), .WINDOW(3), .FLUSH_CYCLES(2)) dut_a (
    .clock(clock), .reset(reset), .if_instr(if_instr), .if_valid(if_valid),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy), .pc_en(a_pc), .ifid_en(a_ifid),
    .decode_flush(a_fl), .stall(a_st), .stall_count(a_sc), .flush_count(a_fc));

  hazard_controller #(.FORWARDING(0), .WINDOW(3), .FLUSH_CYCLES(1)) dut_b (
    .clock(clock), .reset(reset), .if_instr(if_instr), .if_valid(if_valid),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy), .pc_en(b_pc), .ifid_en(b_ifid),
    .decode_flush(b_fl), .stall(b_st), .stall_count(b_sc), .flush_count(b_fc));

  localparam logic [31:0] LW   = 32'h0000A283;
  localparam logic [31:0] ADD  = 32'h00728333;
  localparam logic [31:0] LW0  = 32'h00008003;
  localparam logic [31:0] ADD0 = 32'h00700333;
  localparam logic [31:0] ADDI = 32'h00100193;
  localparam logic [31:0] SW   = 32'h00312023;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: each DUT counts non-freeze edges ("ticks"); a producer
  // issued at tick t sits in window slot (now-1-t).
  int m_fwd [2] = '{1, 0};
  int m_win [2] = '{3, 3};
  int m_fcy [2] = '{2, 1};
  int m_tick[2];
  int m_wt  [2][32];
  bit m_wv  [2][32];
  bit m_wl  [2][32];
  int m_fl  [2];
  int m_sc  [2];
  int m_fc  [2];

  function automatic void m_reset(input int d);
    m_tick[d] = 0;
    m_fl[d] = 0;
    m_sc[d] = 0;
    m_fc[d] = 0;
    for (int r = 0; r < 32; r++) begin
      m_wv[d][r] = 1'b0;
      m_wt[d][r] = 0;
      m_wl[d][r] = 1'b0;
    end
  endfunction

  function automatic bit src_hit(input int d, input logic [4:0] r, input bit used);
    int age;
    if (!used || r == 5'd0 || !m_wv[d][r]) return 1'b0;
    age = m_tick[d] - 1 - m_wt[d][r];
    if (m_fwd[d] != 0) return (age == 0) && m_wl[d][r];
    return age < m_win[d];
  endfunction

  function automatic bit m_hazard(input int d);
    bit u1, u2;
    u1 = 1'b0;
    u2 = 1'b0;
    case (if_instr[6:0])
      7'b0110011, 7'b0100011, 7'b1100011: begin u1 = 1'b1; u2 = 1'b1; end
      7'b0010011, 7'b0000011, 7'b1100111: u1 = 1'b1;
      default: ;
    endcase
    if (!if_valid) return 1'b0;
    return src_hit(d, if_instr[19:15], u1) || src_hit(d, if_instr[24:20], u2);
  endfunction

  function automatic bit m_writes(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                      7'b0110111, 7'b0010111, 7'b1101111};
  endfunction

  function automatic logic [35:0] m_expect(input int d);
    logic [3:0] o;
    if (reset)                            o = 4'b0010;
    else if (mem_busy)                    o = 4'b0000;
    else if (ex_redirect || m_fl[d] > 0)  o = 4'b1110;
    else if (m_hazard(d))                 o = 4'b0011;
    else                                  o = 4'b1100;
    return {o, 16'(m_sc[d]), 16'(m_fc[d])};
  endfunction

  function automatic void m_edge(input int d);
    logic [4:0] rd;
    if (reset) begin
      m_reset(d);
      return;
    end
    if (mem_busy) return;
    rd = if_instr[11:7];
    if (ex_redirect) begin
      m_fc[d] = (m_fc[d] < 65535) ? m_fc[d] + 1 : 65535;
      m_fl[d] = m_fcy[d];
    end else if (m_fl[d] > 0) begin
      m_fl[d] = m_fl[d] - 1;
    end else if (m_hazard(d)) begin
      m_sc[d] = (m_sc[d] < 65535) ? m_sc[d] + 1 : 65535;
    end else if (if_valid && m_writes(if_instr[6:0]) && rd != 5'd0) begin
      m_wv[d][rd] = 1'b1;
      m_wt[d][rd] = m_tick[d];
      m_wl[d][rd] = (if_instr[6:0] == 7'b0000011);
    end
    m_tick[d] = m_tick[d] + 1;
  endfunction

  // Called at the falling edge; drives inputs and compares both DUTs to the model.
  task automatic apply(input logic rst, input logic [31:0] ins, input logic v,
                       input logic redir, input logic busy);
    reset       = rst;
    if_instr    = ins;
    if_valid    = v;
    ex_redirect = redir;
    mem_busy    = busy;
    if (rst) begin
      m_reset(0);
      m_reset(1);
    end
    #2;
    check("model_a", {a_pc, a_ifid, a_fl, a_st, a_sc, a_fc}, m_expect(0));
    check("model_b", {b_pc, b_ifid, b_fl, b_st, b_sc, b_fc}, m_expect(1));
  endtask

  task automatic tick();
    @(posedge clock);
    m_edge(0);
    m_edge(1);
    @(negedge clock);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic        v;
    logic        redir;
    logic        busy;
    logic [3:0]  exp_o;
    logic [15:0] exp_sc;
    logic [15:0] exp_fc;
  } vec_t;

  vec_t tbl [25];

  logic [6:0] ops [10] = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b0000011,
                           7'b1100111, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1111111};

  function automatic logic [31:0] rnd_instr();
    logic [6:0] op;
    logic [4:0] rd, r1, r2;
    logic [2:0] f3;
    op = ops[$urandom_range(0, 9)];
    rd = 5'($urandom_range(0, 7));
    r1 = 5'($urandom_range(0, 7));
    r2 = 5'($urandom_range(0, 7));
    f3 = 3'($urandom_range(0, 7));
    return {7'b0, r2, r1, f3, rd, op};
  endfunction

  initial begin
    // Expected outputs {pc_en, ifid_en, decode_flush, stall} for dut_a
    // (forwarding, window 3, two extra flush cycles), counters as seen that cycle.
    tbl[0]  = '{LW,   1'b1, 1'b0, 1'b0, 4'b1100, 16'd0, 16'd0};
    tbl[1]  = '{ADD,  1'b1, 1'b0, 1'b0, 4'b0011, 16'd0, 16'd0};
    tbl[2]  = '{ADD,  1'b1, 1'b0, 1'b0, 4'b1100, 16'd1, 16'd0};
    tbl[3]  = '{LW0,  1'b1, 1'b0, 1'b0, 4'b1100, 16'd1, 16'd0};
    tbl[4]  = '{ADD0, 1'b1, 1'b0, 1'b0, 4'b1100, 16'd1, 16'd0};
    tbl[5]  = '{LW,   1'b1, 1'b0, 1'b0, 4'b1100, 16'd1, 16'd0};
    tbl[6]  = '{ADD,  1'b0, 1'b0, 1'b0, 4'b1100, 16'd1, 16'd0};
    tbl[7]  = '{ADD,  1'b1, 1'b0, 1'b0, 4'b1100, 16'd1, 16'd0};
    tbl[8]  = '{LW,   1'b1, 1'b0, 1'b0, 4'b1100, 16'd1, 16'd0};
    tbl[9]  = '{ADD,  1'b1, 1'b0, 1'b1, 4'b0000, 16'd1, 16'd0};
    tbl[10] = '{ADD,  1'b1, 1'b0, 1'b1, 4'b0000, 16'd1, 16'd0};
    tbl[11] = '{ADD,  1'b1, 1'b0, 1'b1, 4'b0000, 16'd1, 16'd0};
    tbl[12] = '{ADD,  1'b1, 1'b0, 1'b1, 4'b0000, 16'd1, 16'd0};
    tbl[13] = '{ADD,  1'b1, 1'b0, 1'b0, 4'b0011, 16'd1, 16'd0};
    tbl[14] = '{ADD,  1'b1, 1'b0, 1'b0, 4'b1100, 16'd2, 16'd0};
    tbl[15] = '{LW,   1'b1, 1'b1, 1'b0, 4'b1110, 16'd2, 16'd0};
    tbl[16] = '{ADD,  1'b1, 1'b0, 1'b0, 4'b1110, 16'd2, 16'd1};
    tbl[17] = '{ADD,  1'b1, 1'b0, 1'b0, 4'b1110, 16'd2, 16'd1};
    tbl[18] = '{ADD,  1'b1, 1'b0, 1'b0, 4'b1100, 16'd2, 16'd1};
    tbl[19] = '{ADD,  1'b1, 1'b1, 1'b1, 4'b0000, 16'd2, 16'd1};
    tbl[20] = '{ADD,  1'b1, 1'b1, 1'b0, 4'b1110, 16'd2, 16'd1};
    tbl[21] = '{ADD,  1'b1, 1'b1, 1'b0, 4'b1110, 16'd2, 16'd2};
    tbl[22] = '{ADD,  1'b1, 1'b0, 1'b0, 4'b1110, 16'd2, 16'd3};
    tbl[23] = '{ADD,  1'b1, 1'b0, 1'b0, 4'b1110, 16'd2, 16'd3};
    tbl[24] = '{ADDI, 1'b1, 1'b0, 1'b0, 4'b1100, 16'd2, 16'd3};

    reset = 1'b1;
    if_instr = 32'h0;
    if_valid = 1'b0;
    ex_redirect = 1'b0;
    mem_busy = 1'b0;
    m_reset(0);
    m_reset(1);
    @(negedge clock);

    apply(1'b1, ADD, 1'b1, 1'b1, 1'b0);
    check("reset_out_a", {a_pc, a_ifid, a_fl, a_st, a_sc, a_fc}, {4'b0010, 32'h0});
    check("reset_out_b", {b_pc, b_ifid, b_fl, b_st, b_sc, b_fc}, {4'b0010, 32'h0});
    tick();
    apply(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();

    for (int i = 0; i < 25; i++) begin
      apply(1'b0, tbl[i].instr, tbl[i].v, tbl[i].redir, tbl[i].busy);
      check($sformatf("vec%0d", i), {a_pc, a_ifid, a_fl, a_st, a_sc, a_fc},
            {tbl[i].exp_o, tbl[i].exp_sc, tbl[i].exp_fc});
      tick();
    end

    // RAW without forwarding: producer in slot 0 costs three bubbles.
    apply(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    apply(1'b0, ADDI, 1'b1, 1'b0, 1'b0);
    check("raw_addi_issue", {b_pc, b_fl, b_st}, 3'b100);
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, SW, 1'b1, 1'b0, 1'b0);
      check($sformatf("raw_stall%0d", i), {b_pc, b_ifid, b_fl, b_st}, 4'b0011);
      tick();
    end
    apply(1'b0, SW, 1'b1, 1'b0, 1'b0);
    check("raw_sw_issue", {b_pc, b_ifid, b_fl, b_st}, 4'b1100);
    check("raw_stall_count", b_sc, 16'd3);
    tick();

    // Reset asserted in the middle of a flush sequence.
    apply(1'b0, ADDI, 1'b1, 1'b1, 1'b0);
    tick();
    apply(1'b0, ADDI, 1'b1, 1'b0, 1'b0);
    check("flush_active", {a_pc, a_fl, a_fc}, {2'b11, 16'd1});
    apply(1'b1, ADDI, 1'b1, 1'b0, 1'b0);
    check("rst_mid_flush", {a_pc, a_ifid, a_fl, a_st, a_sc, a_fc}, {4'b0010, 32'h0});
    tick();
    apply(1'b0, ADDI, 1'b1, 1'b0, 1'b0);
    check("post_rst_run", {a_pc, a_ifid, a_fl, a_st}, 4'b1100);
    tick();

    for (int i = 0; i < 2000; i++) begin
      apply(($urandom_range(0, 299) == 0), rnd_instr(), ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 11) == 0), ($urandom_range(0, 7) == 0));
      tick();
    end

    // Hold a redirect long enough to drive flush_count into saturation.
    apply(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 65540; i++) begin
      apply(1'b0, ADDI, 1'b1, 1'b1, 1'b0);
      tick();
    end
    apply(1'b0, ADDI, 1'b1, 1'b0, 1'b0);
    check("flush_sat_a", a_fc, 16'hFFFF);
    check("flush_sat_b", b_fc, 16'hFFFF);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
